// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the instruction memory loader.
interface inst_mem_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    // master: the loader itself; slave: byte source plus RAM write port
    modport master (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Loads a length-prefixed little-endian byte image into the instruction RAM and holds the core
// in reset until it is complete. Define LOADER_CHECKSUM_EN to require a trailing XOR byte.
module inst_mem_loader #(
    parameter int unsigned DEPTH = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    inst_mem_loader_if.master   bus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic                cpu_hold
);
    localparam int unsigned AW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        StIdle, StHdr, StData, StWrite, StChk, StDone, StErr
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] word_q, word_d;
    logic [AW-1:0] n_q, n_d;
    logic [1:0]    byte_q, byte_d;
    logic [31:0]   data_q, data_d;
    logic [7:0]    csum_q, csum_d;
    logic          in_ready;
    logic          wr_en;
    logic          accept;
    int unsigned   hdr_n;

    assign accept = bus.in_valid && in_ready;
    // A zero header means a full-depth image
    assign hdr_n  = (bus.in_data == 8'd0) ? DEPTH : 32'(bus.in_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            word_q  <= '0;
            n_q     <= '0;
            byte_q  <= '0;
            data_q  <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            n_q     <= n_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
            csum_q  <= csum_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        n_d      = n_q;
        byte_d   = byte_q;
        data_d   = data_q;
        csum_d   = csum_q;
        in_ready = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) state_d = StHdr;
            end
            StHdr: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (hdr_n > DEPTH) begin
                        state_d = StErr;
                    end else begin
                        n_d     = AW'(hdr_n);
                        word_d  = '0;
                        byte_d  = '0;
                        csum_d  = '0;
                        state_d = StData;
                    end
                end
            end
            StData: begin
                in_ready = 1'b1;
                if (accept) begin
                    data_d[8*byte_q +: 8] = bus.in_data;
                    csum_d                = csum_q ^ bus.in_data;
                    byte_d                = byte_q + 2'd1;
                    if (byte_q == 2'd3) state_d = StWrite;
                end
            end
            StWrite: begin
                wr_en  = 1'b1;
                word_d = word_q + AW'(1);
                if (word_d == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = StChk;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StData;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StChk: begin
                in_ready = 1'b1;
                if (accept) state_d = (bus.in_data == csum_q) ? StDone : StErr;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = 32'(word_q);
    assign bus.wr_data  = data_q;
    assign busy     = (state_q == StHdr) || (state_q == StData) ||
                      (state_q == StWrite) || (state_q == StChk);
    assign done     = (state_q == StDone);
    assign error    = (state_q == StErr);
    assign cpu_hold = (state_q != StDone);
endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomised self-checking bench for inst_mem_loader; expected writes and final status come
// from a queue model of the image format. Honours LOADER_CHECKSUM_EN when defined.
module tb_inst_mem_loader;
    localparam int unsigned DEPTH = 128;

    logic clk = 1'b0;
    logic reset, start;
    logic busy, done, error, cpu_hold;

    inst_mem_loader_if bus ();

    inst_mem_loader #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    wr_t         exp_q[$];
    int unsigned log_addr[$];
    logic [31:0] log_data[$];
    bit          chk_done_next = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Every cycle: writes must match the model in order, never overlap an accept window
    always @(negedge clk) begin
        if (!reset) begin
            if (chk_done_next) begin
                check("done_after_last_write", {31'd0, done}, 32'd1);
                chk_done_next = 1'b0;
            end
            check("hold_is_not_done", {31'd0, cpu_hold}, {31'd0, !done});
            if (bus.wr_en) begin
                wr_t e;
                log_addr.push_back(bus.wr_addr);
                log_data.push_back(bus.wr_data);
                check("ready_low_in_write", {31'd0, bus.in_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", bus.wr_addr, e.addr);
                    check("wr_data", bus.wr_data, e.data);
`ifndef LOADER_CHECKSUM_EN
                    if (exp_q.size() == 0) chk_done_next = 1'b1;
`endif
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ready_after_start", {31'd0, bus.in_ready}, 32'd1);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_cleared", {31'd0, done}, 32'd0);
        check("error_cleared", {31'd0, error}, 32'd0);
    endtask

    // Offers the stream with random gaps; advances only on a real handshake
    task automatic feed(input logic [7:0] s[$], input int unsigned gap_pct);
        int idx = 0;
        int cyc = 0;
        while (idx < s.size() && cyc < 20000) begin
            if ($urandom_range(99) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = s[idx];
            end
            if (bus.in_valid && bus.in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (idx < s.size()) begin
            n_cmp++;
            n_bad++;
            $display("FAIL feed_timeout: accepted %0d of %0d bytes", idx, s.size());
        end
    endtask

    task automatic run_load(input logic [7:0] hdr, input logic [7:0] d[$],
                            input int unsigned gap_pct, input bit bad_ck);
        int unsigned n = (hdr == 8'd0) ? DEPTH : int'(hdr);
        bit          over = (n > DEPTH);
        bit          exp_ok;
        logic [7:0]  s[$];
        logic [7:0]  x = 8'd0;
        int          w = 0;
        s.push_back(hdr);
        if (!over) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_q.push_back('{addr: i, data: {d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]}});
                for (int k = 0; k < 4; k++) begin
                    s.push_back(d[4*i+k]);
                    x ^= d[4*i+k];
                end
            end
        end
`ifdef LOADER_CHECKSUM_EN
        if (!over) s.push_back(x ^ {7'd0, bad_ck});
        exp_ok = !over && !bad_ck;
`else
        exp_ok = !over;
`endif
        log_addr.delete();
        log_data.delete();
        pulse_start();
        feed(s, gap_pct);
        while (!(done || error) && w < 30) begin
            @(negedge clk);
            w++;
        end
        check("final_done", {31'd0, done}, {31'd0, exp_ok});
        check("final_error", {31'd0, error}, {31'd0, !exp_ok});
        check("final_hold", {31'd0, cpu_hold}, {31'd0, !exp_ok});
        check("writes_outstanding", exp_q.size(), 32'd0);
        check("ready_low_after", {31'd0, bus.in_ready}, 32'd0);
        exp_q.delete();
    endtask

    task automatic rand_bytes(input int cnt, output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < cnt; i++) q.push_back(8'($urandom));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_wr_en"}, {31'd0, bus.wr_en}, 32'd0);
        check({tag, "_wr_addr"}, bus.wr_addr, 32'd0);
        check({tag, "_wr_data"}, bus.wr_data, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    endtask

    initial begin
        logic [7:0] d[$];
        logic [7:0] part[$];
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;

        // Basic two-word image, pinned with literal words
        d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(8'd2, d, 0, 1'b0);
        check("basic_count", log_data.size(), 32'd2);
        check("basic_word0", log_data[0], 32'h0000_0013);
        check("basic_word1", log_data[1], 32'h0010_0093);
        check("basic_addr1", log_addr[1], 32'd1);

        // Full depth via L=0, word i = i
        d.delete();
        for (int i = 0; i < int'(DEPTH); i++) begin
            d.push_back(8'(i));
            d.push_back(8'd0);
            d.push_back(8'd0);
            d.push_back(8'd0);
        end
        run_load(8'd0, d, 0, 1'b0);
        check("full_count", log_data.size(), DEPTH);
        check("full_last_addr", log_addr[DEPTH-1], 32'd127);
        check("full_last_word", log_data[DEPTH-1], 32'd127);

        // Oversize header, then recovery with L=1
        d.delete();
        run_load(8'h81, d, 0, 1'b0);
        check("oversize_no_writes", log_data.size(), 32'd0);
        rand_bytes(4, d);
        run_load(8'd1, d, 20, 1'b0);
        check("recover_count", log_data.size(), 32'd1);

        // Random images with backpressure gaps
        repeat (8) begin
            int unsigned l = $urandom_range(1, 24);
            rand_bytes(4 * l, d);
            run_load(8'(l), d, $urandom_range(0, 70), 1'b0);
        end
        d.delete();
        run_load(8'($urandom_range(129, 255)), d, 30, 1'b0);

        // Reset mid-DATA, then reload from index 0
        pulse_start();
        part = '{8'd3, 8'hAA, 8'hBB};
        feed(part, 0);
        #2 reset = 1'b1;
        #1 check_reset_values("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        rand_bytes(8, d);
        run_load(8'd2, d, 40, 1'b0);
        check("reload_first_addr", log_addr[0], 32'd0);

`ifdef LOADER_CHECKSUM_EN
        d = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(8'd1, d, 0, 1'b0);
        run_load(8'd1, d, 0, 1'b1);
        check("ck_bad_word_written", log_data[0], 32'h0403_0201);
        check("ck_bad_addr", log_addr[0], 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
